div_ctrl: RTL and testbench

- Control unit for the iterative restoring divider.
- Sequences three external loadable left-shift registers: R (partial remainder), A (dividend, shifted out MSB-first) and Q (quotient, shifted in LSB-first).
- Also drives the B (divisor) register load.
- Provides a start/busy/done handshake and a divide-by-zero error; consumes the datapath comparator result geq (R >= B).

---
 rtl/div_ctrl_pkg.sv | 69 ++++++
 rtl/div_ctrl_if.sv | 48 ++++
 rtl/div_ctrl.sv | 121 ++++++++++++
 tb/tb_div_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the iterative restoring divider.
//   - DIV_N        : default operand width
//   - state_t      : controller state encoding (IDLE, LOAD, SHIFT, SUB, DONE)
//   - ctrl_word_t  : register-control bundle; the field order here is the bit
//                    order the top-level divider uses when it packs the
//                    controls into one word
//   - decode_ctrl  : Moore decode of the register controls from the state
//                    (q_w is handled separately because it follows geq)
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SUB   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // MSB first: b_ld is bit 8, q_E is bit 0.
    typedef struct packed {
        logic b_ld;
        logic r_sclr;
        logic r_sL;
        logic r_E;
        logic a_sL;
        logic a_E;
        logic q_sclr;
        logic q_sL;
        logic q_E;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NONE = '0;

    // Register controls for a given state. In SUB the R enable depends on
    // the comparator: R only takes the difference when R >= B (restoring).
    function automatic ctrl_word_t decode_ctrl(input state_t st, input logic geq);
        ctrl_word_t cw;
        cw = CTRL_NONE;
        case (st)
            ST_LOAD: begin
                cw.b_ld   = 1'b1;
                cw.r_sclr = 1'b1;
                cw.r_E    = 1'b1;
                cw.a_sL   = 1'b1;
                cw.a_E    = 1'b1;
                cw.q_sclr = 1'b1;
                cw.q_E    = 1'b1;
            end
            ST_SHIFT: begin
                // r_sL = 0: R shifts in A's MSB through datapath wiring.
                cw.r_E = 1'b1;
                cw.a_E = 1'b1;
            end
            ST_SUB: begin
                cw.r_sL = 1'b1;
                cw.r_E  = geq;
                cw.q_E  = 1'b1;
            end
            default: cw = CTRL_NONE;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Handshake and datapath-control bundle between the divider controller and
// the divider datapath / requester.
//   Requester/datapath -> controller : start, b_zero, geq
//   Controller -> datapath           : b_ld, r_sclr, r_sL, r_E, a_sL, a_E,
//                                      q_sclr, q_sL, q_E, q_w
//   Controller -> requester          : busy, done, err
// Modports:
//   master : the controller (div_ctrl)
//   slave  : the datapath / requester side
// -----------------------------------------------------------------------------
interface div_ctrl_if;

    logic start;
    logic b_zero;
    logic geq;

    logic b_ld;
    logic r_sclr;
    logic r_sL;
    logic r_E;
    logic a_sL;
    logic a_E;
    logic q_sclr;
    logic q_sL;
    logic q_E;
    logic q_w;

    logic busy;
    logic done;
    logic err;

    modport master (
        input  start, b_zero, geq,
        output b_ld, r_sclr, r_sL, r_E, a_sL, a_E,
        output q_sclr, q_sL, q_E, q_w,
        output busy, done, err
    );

    modport slave (
        output start, b_zero, geq,
        input  b_ld, r_sclr, r_sL, r_E, a_sL, a_E,
        input  q_sclr, q_sL, q_E, q_w,
        input  busy, done, err
    );

endinterface

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Control unit for an N-bit iterative restoring divider. Sequences the
// external R (partial remainder), A (dividend) and Q (quotient) shift
// registers plus the B (divisor) load, one quotient bit per SHIFT/SUB pair.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; returns to IDLE, clears counter and err
//   bus    : div_ctrl_if.master
//              start  - request a division (only looked at in IDLE)
//              b_zero - divisor bus is zero
//              geq    - R >= B from the datapath comparator
//              b_ld, r_*, a_*, q_* - register controls (Moore decodes)
//              q_w    - quotient bit, equals geq in SUB, 0 elsewhere
//              busy   - LOAD/SHIFT/SUB in progress
//              done   - one-cycle completion pulse
//              err    - last accepted request had a zero divisor
//
// q_sL is permanently 0: Q is only ever cleared or shifted, never loaded.
// A zero divisor goes straight from IDLE to DONE with no register enables,
// so Q and R keep stale contents and err marks them invalid.
// -----------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic  clk,
    input  logic  reset,
    div_ctrl_if.master bus
);

    localparam int CW = $clog2(N);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          err_q;
    logic          err_nx;

    ctrl_word_t    cw;
    logic          busy;
    logic          done;
    logic          q_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = err_q;
        busy     = 1'b0;
        done     = 1'b0;
        q_w      = 1'b0;
        cw       = decode_ctrl(state, bus.geq);

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    err_nx   = bus.b_zero;
                    state_nx = bus.b_zero ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                cnt_nx   = CW'(N - 1);
                state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                state_nx = ST_SUB;
            end
            ST_SUB: begin
                busy = 1'b1;
                q_w  = bus.geq;
                // cnt counts remaining iterations after this one.
                if (cnt == '0) begin
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx   = cnt - CW'(1);
                    state_nx = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // start is ignored here; a held start is picked up in IDLE.
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.b_ld   = cw.b_ld;
    assign bus.r_sclr = cw.r_sclr;
    assign bus.r_sL   = cw.r_sL;
    assign bus.r_E    = cw.r_E;
    assign bus.a_sL   = cw.a_sL;
    assign bus.a_E    = cw.a_E;
    assign bus.q_sclr = cw.q_sclr;
    assign bus.q_sL   = cw.q_sL;
    assign bus.q_E    = cw.q_E;
    assign bus.q_w    = q_w;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Directed testbench for div_ctrl (N=4) with a small restoring-divider
// datapath model driven by the controller outputs.
// Cycle numbering: cycle k is the interval following rising edge k; the edge
// on which start is accepted is edge t.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] din_a;
    logic [3:0] din_b;

    logic [4:0] dp_r;
    logic [3:0] dp_a;
    logic [3:0] dp_q;
    logic [3:0] dp_b;

    int n_checks;
    int n_pass;

    int   excl_viol;
    int   mon_cycles;
    logic prev_done;

    // {b_ld,r_sclr,r_sL,r_E,a_sL,a_E,q_sclr,q_sL,q_E,q_w,busy,done,err}
    logic [12:0] ov;

    localparam logic [12:0] V_IDLE     = 13'b0000000000000;
    localparam logic [12:0] V_LOAD     = 13'b1101111010100;
    localparam logic [12:0] V_SHIFT    = 13'b0001010000100;
    localparam logic [12:0] V_SUB0     = 13'b0010000010100;
    localparam logic [12:0] V_SUB1     = 13'b0011000011100;
    localparam logic [12:0] V_DONE     = 13'b0000000000010;
    localparam logic [12:0] V_DONE_ERR = 13'b0000000000011;
    localparam logic [12:0] V_ERR      = 13'b0000000000001;

    div_ctrl_if bus ();

    div_ctrl #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ov = {bus.b_ld, bus.r_sclr, bus.r_sL, bus.r_E, bus.a_sL, bus.a_E,
                 bus.q_sclr, bus.q_sL, bus.q_E, bus.q_w, bus.busy, bus.done, bus.err};

    // Datapath model: R is one bit wider so the shifted remainder cannot overflow.
    assign bus.geq    = (dp_r >= {1'b0, dp_b});
    assign bus.b_zero = (din_b == 4'd0);

    always @(posedge clk) begin
        if (reset) begin
            dp_r <= '0;
            dp_a <= '0;
            dp_q <= '0;
            dp_b <= '0;
        end else begin
            if (bus.b_ld) dp_b <= din_b;
            if (bus.r_E) begin
                if (bus.r_sclr)    dp_r <= '0;
                else if (bus.r_sL) dp_r <= dp_r - {1'b0, dp_b};
                else               dp_r <= {dp_r[3:0], dp_a[3]};
            end
            if (bus.a_E) dp_a <= bus.a_sL ? din_a : {dp_a[2:0], 1'b0};
            if (bus.q_E) dp_q <= bus.q_sclr ? 4'd0 : {dp_q[2:0], bus.q_w};
        end
    end

    // Per-cycle control exclusivity monitor, judged in test_exclusivity.
    initial begin
        excl_viol  = 0;
        mon_cycles = 0;
        prev_done  = 1'b0;
    end

    always @(negedge clk) begin
        mon_cycles = mon_cycles + 1;
        if ((bus.r_sclr & bus.r_sL) !== 1'b0 || bus.q_sL !== 1'b0 ||
            (bus.done & bus.busy) !== 1'b0 || (bus.done & prev_done) !== 1'b0)
            excl_viol = excl_viol + 1;
        prev_done = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        din_a     = a;
        din_b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ov !== V_IDLE) $display("FAIL reset_hold outputs=%b expected=%b", ov, V_IDLE);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (ov !== V_IDLE) $display("FAIL reset_idle outputs=%b expected=%b", ov, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_normal();
        logic [3:0] qw_seq;
        logic       busy_ok;
        logic       early_done;
        qw_seq     = '0;
        busy_ok    = 1'b1;
        early_done = 1'b0;
        start_op(4'd13, 4'd3);
        n_checks++;
        if (ov !== V_LOAD) $display("FAIL normal_load outputs=%b expected=%b", ov, V_LOAD);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done !== 1'b0) early_done = 1'b1;
            if (i % 2 == 0) qw_seq = {qw_seq[2:0], bus.q_w};
            if (i == 1) begin
                n_checks++;
                if (ov !== V_SHIFT) $display("FAIL normal_shift outputs=%b expected=%b", ov, V_SHIFT);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (ov !== V_SUB0) $display("FAIL normal_sub_geq0 outputs=%b expected=%b", ov, V_SUB0);
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if (ov !== V_SUB1) $display("FAIL normal_sub_geq1 outputs=%b expected=%b", ov, V_SUB1);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_ok !== 1'b1 || early_done !== 1'b0)
            $display("FAIL normal_busy_window busy_ok=%b early_done=%b expected 1/0", busy_ok, early_done);
        else n_pass++;
        n_checks++;
        if (qw_seq !== 4'b0100) $display("FAIL normal_qw_seq got=%b expected=0100", qw_seq);
        else n_pass++;
        tick();
        n_checks++;
        if (ov !== V_DONE) $display("FAIL normal_done_t9 outputs=%b expected=%b", ov, V_DONE);
        else n_pass++;
        n_checks++;
        if (dp_q !== 4'd4 || dp_r !== 5'd1)
            $display("FAIL normal_result Q=%0d R=%0d expected Q=4 R=1", dp_q, dp_r);
        else n_pass++;
        tick();
        n_checks++;
        if (ov !== V_IDLE) $display("FAIL normal_after_done outputs=%b expected=%b", ov, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        logic err_held;
        err_held = 1'b1;
        start_op(4'd9, 4'd0);
        n_checks++;
        if (ov !== V_DONE_ERR) $display("FAIL divzero_done outputs=%b expected=%b", ov, V_DONE_ERR);
        else n_pass++;
        tick();
        n_checks++;
        if (dp_q !== 4'd4 || dp_r !== 5'd1)
            $display("FAIL divzero_regs_kept Q=%0d R=%0d expected Q=4 R=1", dp_q, dp_r);
        else n_pass++;
        n_checks++;
        if (ov !== V_ERR) $display("FAIL divzero_idle outputs=%b expected=%b", ov, V_ERR);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ov !== V_ERR) err_held = 1'b0;
        end
        n_checks++;
        if (err_held !== 1'b1) $display("FAIL divzero_err_held got=%b expected=1", err_held);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        start_op(4'd13, 4'd3);
        n_checks++;
        if (ov !== V_LOAD) $display("FAIL resetmid_load_err_cleared outputs=%b expected=%b", ov, V_LOAD);
        else n_pass++;
        for (int i = 1; i <= 4; i++) tick();
        n_checks++;
        if (ov !== V_SUB1) $display("FAIL resetmid_second_sub outputs=%b expected=%b", ov, V_SUB1);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (ov !== V_IDLE) $display("FAIL resetmid_idle outputs=%b expected=%b", ov, V_IDLE);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL resetmid_no_done dones=%0d expected=0", dones);
        else n_pass++;
        start_op(4'd15, 4'd1);
        for (int i = 1; i <= 9; i++) tick();
        n_checks++;
        if (bus.done !== 1'b1 || dp_q !== 4'd15 || dp_r !== 5'd0)
            $display("FAIL resetmid_15_1 done=%b Q=%0d R=%0d expected done=1 Q=15 R=0", bus.done, dp_q, dp_r);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_busy();
        int         dones;
        int         done_at;
        logic [3:0] q_at;
        logic [4:0] r_at;
        dones   = 0;
        done_at = -1;
        q_at    = '0;
        r_at    = '0;
        start_op(4'd14, 4'd4);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) bus.start = 1'b1;
            if (i == 3) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                done_at = i;
                q_at    = dp_q;
                r_at    = dp_r[3:0];
            end
        end
        n_checks++;
        if (dones !== 1 || done_at !== 9)
            $display("FAIL startbusy_single_done dones=%0d at=%0d expected 1 at 9", dones, done_at);
        else n_pass++;
        n_checks++;
        if (q_at !== 4'd3 || r_at !== 5'd2)
            $display("FAIL startbusy_result Q=%0d R=%0d expected Q=3 R=2", q_at, r_at);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        din_a     = 4'd13;
        din_b     = 4'd3;
        bus.start = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) tick();
        tick();
        n_checks++;
        if (ov !== V_DONE || dp_q !== 4'd4)
            $display("FAIL b2b_first_done outputs=%b Q=%0d expected %b Q=4", ov, dp_q, V_DONE);
        else n_pass++;
        din_a = 4'd7;
        din_b = 4'd2;
        tick();
        n_checks++;
        if (ov !== V_IDLE) $display("FAIL b2b_idle outputs=%b expected=%b", ov, V_IDLE);
        else n_pass++;
        tick();
        n_checks++;
        if (ov !== V_LOAD) $display("FAIL b2b_second_load outputs=%b expected=%b", ov, V_LOAD);
        else n_pass++;
        bus.start = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        n_checks++;
        if (bus.done !== 1'b1 || dp_q !== 4'd3 || dp_r !== 5'd1)
            $display("FAIL b2b_7_2 done=%b Q=%0d R=%0d expected done=1 Q=3 R=1", bus.done, dp_q, dp_r);
        else n_pass++;
        tick();
    endtask

    task automatic test_exclusivity();
        n_checks++;
        if (mon_cycles < 50) $display("FAIL excl_monitor_cycles got=%0d expected>=50", mon_cycles);
        else n_pass++;
        n_checks++;
        if (excl_viol !== 0) $display("FAIL excl_violations got=%0d expected=0", excl_viol);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        din_a     = 4'd0;
        din_b     = 4'd1;
        bus.start = 1'b0;

        test_reset();
        test_normal();
        test_div_zero();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_exclusivity();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
